// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | fifo_uart_tx                                                        |
// | Pops words from a registered-output fifo and sends each one as an   |
// | asynchronous serial frame: start, data LSB first, parity, stop.     |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_in,
    output logic             rd,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(WIDTH + 1);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
    localparam logic                c_PAR_EN    = (PARITY_EN != 0);
    localparam logic                c_PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_POP    = 3'd1;
    localparam logic [2:0] c_ST_LOAD   = 3'd2;
    localparam logic [2:0] c_ST_START  = 3'd3;
    localparam logic [2:0] c_ST_DATA   = 3'd4;
    localparam logic [2:0] c_ST_PARITY = 3'd5;
    localparam logic [2:0] c_ST_STOP   = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BIT_W-1:0]  r_bit;
    logic [WIDTH-1:0]    r_shift;
    logic                r_parity;
    logic                r_tx;
    logic                r_done;

    logic w_baud_last;
    logic w_data_last;
    logic w_stop_last;
    logic w_start_ok;

    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_data_last = (r_bit == c_DATA_LAST);
    assign w_stop_last = (r_bit == c_STOP_LAST);
    assign w_start_ok  = tx_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_start_ok) w_next = c_ST_POP;
            c_ST_POP:    w_next = c_ST_LOAD;
            c_ST_LOAD:   w_next = c_ST_START;
            c_ST_START:  if (w_baud_last) w_next = c_ST_DATA;
            c_ST_DATA: begin
                if (w_baud_last && w_data_last) begin
                    w_next = c_PAR_EN ? c_ST_PARITY : c_ST_STOP;
                end
            end
            c_ST_PARITY: if (w_baud_last) w_next = c_ST_STOP;
            c_ST_STOP: begin
                // Chaining straight into POP is what removes the idle gap.
                if (w_baud_last && w_stop_last) begin
                    w_next = w_start_ok ? c_ST_POP : c_ST_IDLE;
                end
            end
            default:     w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_LOAD: begin
                    // data_in is valid here, one cycle after the POP strobe.
                    r_shift  <= data_in;
                    r_parity <= (^data_in) ^ c_PAR_ODD;
                    r_tx     <= 1'b0;
                    r_baud   <= '0;
                    r_bit    <= '0;
                end
                c_ST_START, c_ST_DATA, c_ST_PARITY, c_ST_STOP: begin
                    r_baud <= w_baud_last ? '0 : r_baud + c_BAUD_W'(1);
                    if (w_baud_last) begin
                        case (r_state)
                            c_ST_START: begin
                                r_tx    <= r_shift[0];
                                r_shift <= r_shift >> 1;
                            end
                            c_ST_DATA: begin
                                if (w_data_last) begin
                                    r_bit <= '0;
                                    r_tx  <= c_PAR_EN ? r_parity : 1'b1;
                                end else begin
                                    r_bit   <= r_bit + c_BIT_W'(1);
                                    r_tx    <= r_shift[0];
                                    r_shift <= r_shift >> 1;
                                end
                            end
                            c_ST_PARITY: begin
                                r_bit <= '0;
                                r_tx  <= 1'b1;
                            end
                            c_ST_STOP: begin
                                if (w_stop_last) begin
                                    r_bit  <= '0;
                                    r_done <= 1'b1;
                                end else begin
                                    r_bit <= r_bit + c_BIT_W'(1);
                                end
                            end
                            default: begin
                                r_tx <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    r_tx   <= 1'b1;
                end
            endcase
        end
    end

    assign rd   = (r_state == c_ST_POP);
    assign busy = (r_state != c_ST_IDLE);
    assign tx   = r_tx;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// Three parameter lanes (plain, even parity + 2 stop, odd parity) share one
// stimulus; each lane owns a fifo and a frame-level expectation model.
module tb_fifo_uart_tx;
    localparam int NL  = 3;
    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tx_en = 1'b0;
    logic       push  = 1'b0;
    logic [7:0] pdata = '0;

    logic [NL-1:0] rd_v, tx_v, busy_v, done_v, empty_v;
    logic [NL-1:0] erd_v, etx_v, ebusy_v, edone_v;

    int checks = 0;
    int errors = 0;
    int rd_cnt   [NL];
    int done_cnt [NL];

    always #5 clk = ~clk;

    // Bit p of a serial frame: 0 start, 1..8 data LSB first, then parity, then stop.
    function automatic logic frame_bit(int pe, int po, logic [7:0] d, int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
        if (pe != 0 && p == 9) return (^d) ^ (po != 0);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int PE   = (g == 0) ? 0 : 1;
        localparam int PO   = (g == 2) ? 1 : 0;
        localparam int SB   = (g == 1) ? 2 : 1;
        localparam int FLEN = (1 + 8 + PE + SB) * CPB;

        logic       fifo_empty = 1'b1;
        logic [7:0] fifo_dout  = '0;
        logic       e_rd, e_tx, e_busy, e_done;
        logic [7:0] q [$];

        fifo_uart_tx #(
            .WIDTH       (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .tx_en  (tx_en),
            .empty  (fifo_empty),
            .data_in(fifo_dout),
            .rd     (rd_v[g]),
            .tx     (tx_v[g]),
            .busy   (busy_v[g]),
            .done   (done_v[g])
        );

        assign empty_v[g] = fifo_empty;
        assign erd_v[g]   = e_rd;
        assign etx_v[g]   = e_tx;
        assign ebusy_v[g] = e_busy;
        assign edone_v[g] = e_done;

        // Frame-level model: a frame popped in cycle t occupies t..t+1+FLEN,
        // the serial bits start at t+2 and done follows the last stop cycle.
        initial begin
            longint     cyc, t, busy_end, done_cyc;
            logic [7:0] word;
            logic       start;
            cyc = 0; t = -1000; busy_end = -1; done_cyc = -1; word = '0;
            e_rd = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            forever begin
                @(posedge clk);
                start = !rst && (cyc >= busy_end) && tx_en && !fifo_empty && (q.size() > 0);
                if (start) word = q[0];
                if (rd_v[g] && q.size() > 0) fifo_dout <= q.pop_front();
                if (push) q.push_back(pdata);
                fifo_empty <= (q.size() == 0);
                cyc++;
                if (rst) begin
                    t = -1000; busy_end = -1; done_cyc = -1;
                end
                e_done = (cyc == done_cyc);
                if (start) begin
                    t        = cyc;
                    busy_end = t + 1 + FLEN;
                    done_cyc = t + 2 + FLEN;
                end
                e_rd   = (cyc == t);
                e_busy = (cyc >= t) && (cyc <= busy_end);
                if (cyc >= t + 2 && cyc <= busy_end)
                    e_tx = frame_bit(PE, PO, word, int'((cyc - t - 2) / CPB));
                else
                    e_tx = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare_cycle();
        logic [3:0] a_vec, e_vec;
        for (int i = 0; i < NL; i++) begin
            a_vec = {rd_v[i], tx_v[i], busy_v[i], done_v[i]};
            e_vec = rst ? 4'b0100 : {erd_v[i], etx_v[i], ebusy_v[i], edone_v[i]};
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL lane%0d {rd,tx,busy,done} at t=%0t: got %b, expected %b",
                         i, $time, a_vec, e_vec);
            end
            if (rd_v[i] === 1'b1) begin
                checks++;
                if (empty_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL lane%0d rd_while_empty at t=%0t: empty=%b, expected 0",
                             i, $time, empty_v[i]);
                end
            end
            rd_cnt[i]   += int'(rd_v[i] === 1'b1);
            done_cnt[i] += int'(done_v[i] === 1'b1);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        push  = 1'b1;
        pdata = d;
        tick();
        push  = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (!(busy_v == '0 && (empty_v == '1 || !tx_en)) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", int'(n < budget), 1);
    endtask

    initial begin
        int         base_rd   [NL];
        int         base_done [NL];
        int         n;
        logic [11:0] smp  [NL];
        logic [11:0] want [NL];

        for (int i = 0; i < NL; i++) begin
            rd_cnt[i] = 0; done_cnt[i] = 0; smp[i] = '0;
        end
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset with empty fifo: line idles, no reads
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < NL; i++) base_rd[i] = rd_cnt[i];
        tx_en = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < NL; i++) chk($sformatf("lane%0d_no_rd_when_empty", i), rd_cnt[i] - base_rd[i], 0);
        chk("idle_tx_high", int'(tx_v), 7);
        chk("idle_busy_low", int'(busy_v), 0);

        // Single word 8'h0A: latency, bit pattern per lane, one rd, one done
        for (int i = 0; i < NL; i++) begin base_rd[i] = rd_cnt[i]; base_done[i] = done_cnt[i]; end
        push_word(8'h0A);
        n = 0;
        while (tx_v[0] !== 1'b0 && n < 20) begin tick(); n++; end
        chk("start_latency_edges", n, 3);
        repeat (2) tick();
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < NL; i++) smp[i][b] = tx_v[i];
            repeat (CPB) tick();
        end
        want[0] = {3'b111, 8'h0A, 1'b0};
        want[1] = {3'b110, 8'h0A, 1'b0};
        want[2] = {3'b111, 8'h0A, 1'b0};
        for (int i = 0; i < NL; i++) chk($sformatf("lane%0d_frame_bits_0A", i), int'(smp[i]), int'(want[i]));
        wait_idle(200);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("lane%0d_single_rd", i), rd_cnt[i] - base_rd[i], 1);
            chk($sformatf("lane%0d_single_done", i), done_cnt[i] - base_done[i], 1);
        end
        chk("busy_low_after_frame", int'(busy_v), 0);

        // Three words back to back
        for (int i = 0; i < NL; i++) begin base_rd[i] = rd_cnt[i]; base_done[i] = done_cnt[i]; end
        push_word(8'd10);
        push_word(8'd20);
        push_word(8'd30);
        wait_idle(600);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("lane%0d_three_rd", i), rd_cnt[i] - base_rd[i], 3);
            chk($sformatf("lane%0d_three_done", i), done_cnt[i] - base_done[i], 3);
        end

        // tx_en gating: no reads while low, drop during frame 2 stops after it
        tx_en = 1'b0;
        for (int i = 0; i < NL; i++) base_rd[i] = rd_cnt[i];
        for (int w = 40; w <= 80; w += 10) push_word(8'(w));
        repeat (20) tick();
        for (int i = 0; i < NL; i++) chk($sformatf("lane%0d_no_rd_tx_en_low", i), rd_cnt[i] - base_rd[i], 0);
        tx_en = 1'b1;
        n = 0;
        while (rd_cnt[0] == base_rd[0] && n < 10) begin tick(); n++; end
        chk("first_rd_after_tx_en", int'(n < 10), 1);
        repeat (60) tick();
        tx_en = 1'b0;
        wait_idle(400);
        for (int i = 0; i < NL; i++) chk($sformatf("lane%0d_two_frames_then_stop", i), rd_cnt[i] - base_rd[i], 2);
        chk("words_left_in_fifo", int'(empty_v), 0);

        // Asynchronous reset in the middle of the data bits
        for (int i = 0; i < NL; i++) begin base_rd[i] = rd_cnt[i]; base_done[i] = done_cnt[i]; end
        tx_en = 1'b1;
        n = 0;
        while (tx_v[0] !== 1'b0 && n < 20) begin tick(); n++; end
        chk("frame_started_before_reset", int'(n < 20), 1);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_reset_tx_high", int'(tx_v), 7);
        chk("async_reset_busy_low", int'(busy_v), 0);
        repeat (3) tick();
        rst = 1'b0;
        wait_idle(600);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("lane%0d_rd_across_reset", i), rd_cnt[i] - base_rd[i], 3);
            chk($sformatf("lane%0d_done_across_reset", i), done_cnt[i] - base_done[i], 2);
        end

        // Randomized traffic with tx_en toggling and occasional resets
        for (int k = 0; k < 3000; k++) begin
            push  = ($urandom_range(0, 49) == 0);
            pdata = 8'($urandom);
            if ($urandom_range(0, 59) == 0) tx_en = ~tx_en;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 999) == 0) rst = 1'b1;
            tick();
        end
        push  = 1'b0;
        rst   = 1'b0;
        tx_en = 1'b1;
        tick();
        wait_idle(8000);
        chk("fifos_drained", int'(empty_v), 7);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
